dino_score_tx: RTL and testbench
================================

Name: dino_score_tx

Overview:
Transmit side of the score link. Accepts a packed BCD score from the dino score counter over a valid/ready handshake and snapshots it. Shifts the score out MSB-first on a 3-wire serial interface (sclk, sdata, sframe) to the off-chip display/readout device. Sits between the score counter and the uo_out pins inside tt_um_dino_score.

Parameters:
NUM_DIGITS, 4, number of BCD digits per frame; data bits = 4*NUM_DIGITS
CLK_DIV, 4, clk cycles per sclk half-period; legal range 1..255; one bit period = 2*CLK_DIV clk cycles

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
ena  input  1  design enable; when low, no new frame is accepted
score_bcd  input  4*NUM_DIGITS  packed BCD score, most-significant digit in the MSBs
score_valid  input  1  score_bcd is valid this cycle
score_ready  output  1  transmitter can accept a score
sclk  output  1  serial clock, idle low
sdata  output  1  serial data, idle low
sframe  output  1  high for the whole frame
busy  output  1  high whenever state != IDLE
bcd_err  output  1  sticky: accepted score had a nibble > 9

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, divider and bit counter cleared. All outputs 0 at the next edge, except score_ready, which follows its combinational equation (0 while in reset). Reset mid-frame aborts the frame immediately; no partial completion.
- score_ready = (state==IDLE) & ena & rst_n, combinational from registered state. Accept = score_valid & score_ready. On accept: score_bcd is latched into the shift register; bcd_err is loaded with (any nibble > 9); state moves to START. bcd_err holds until the next accept.
- States and transitions:
  - IDLE -> START on accept.
  - START: one bit period, sframe=1, sclk=0, sdata=0.
  - SHIFT: 4*NUM_DIGITS bit periods.
  - STOP: one bit period, sframe=0, sclk=0, sdata=0.
  - STOP -> IDLE.
- SHIFT bit timing:
  - sdata updates on the first clk of each bit period with the shift-register MSB; the register then shifts left.
  - sclk=0 for the first CLK_DIV cycles of the period and 1 for the second CLK_DIV cycles. The receiver samples on the sclk rising edge.
- Frame length = (2 + 4*NUM_DIGITS) bit periods. Default: 18*8 = 144 clk cycles from the accept edge to the return to IDLE. score_ready is high again on the cycle after STOP ends.
- Back-to-back transfers: a valid held high is accepted in the first IDLE cycle; the gap between frames is 1 IDLE cycle.
- ena falling mid-frame: the current frame completes normally; no new accept until ena is high again.
- Changes to score_bcd after accept do not affect the frame in flight.
- Nibbles > 9 are transmitted unmodified; only bcd_err flags them.
- Bit counter width = clog2(4*NUM_DIGITS+1); divider width = 8 bits. Neither counter wraps inside a state; each is cleared on state entry.

Optional Feature:
Macro SCORE_TX_PARITY_EN.
- Defined: one extra bit period is inserted between SHIFT and STOP (state PARITY). sdata carries even parity (XOR of all data bits) and is clocked like a data bit. Frame = 3 + 4*NUM_DIGITS periods (default 152 cycles).
- Undefined: no PARITY state; frame exactly as above.

Decomposition:
- Package dino_score_pkg: state enum (IDLE, START, SHIFT, PARITY, STOP), BCD_W=4, BCD_MAX=9, function frame_bits(num_digits, parity_en).
- One sub-module: dino_bit_timer. It takes CLK_DIV, a restart input, and a run input, and outputs half_tick (end of the low half) and bit_tick (end of the period). The FSM uses bit_tick for state and bit advance and half_tick to raise sclk.

Test Plan:
- Reset, then score_bcd=16'h1234 with valid for 1 cycle, CLK_DIV=4 -> sdata sampled at sclk rises = 0001_0010_0011_0100. sframe high for 136 cycles. busy high for 144 cycles. score_ready high again at cycle 145. bcd_err=0.
- valid held high with scores 16'h0009 then 16'h9999 -> two frames, 1-cycle IDLE gap, second frame bits all correct. score_bcd changed mid-frame does not affect the frame in flight.
- score_bcd=16'h12A4 -> frame transmits 0xA unchanged; bcd_err=1 until the next accept of 16'h0000, which clears it.
- rst_n low for 1 cycle at cycle 50 of a frame -> next edge: sclk=sdata=sframe=busy=0, state IDLE. score_ready=1 on the first cycle after rst_n returns high.
- ena=0 with valid=1 -> score_ready=0, no frame. ena dropped at cycle 20 of a frame -> frame completes in full (144 cycles).
- With SCORE_TX_PARITY_EN, 16'h1234 (five 1s) -> parity bit 1 in period 18. Frame = 152 cycles.

Source files
------------

// File: rtl/dino_score_pkg.sv
// Shared types and constants for the dino score transmit link.
package dino_score_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SHIFT,
        PARITY,
        STOP
    } tx_state_e;

    localparam int unsigned BCD_W   = 4;
    localparam int unsigned BCD_MAX = 9;

    // Bit periods in one frame: start + data bits + optional parity + stop.
    function automatic int unsigned frame_bits(input int unsigned num_digits, input bit parity_en);
        return 2 + BCD_W * num_digits + (parity_en ? 1 : 0);
    endfunction

endpackage

// File: rtl/dino_bit_timer.sv
// Bit-period timer: half_tick ends the sclk-low half, bit_tick ends the whole period.
module dino_bit_timer #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic run,
    output logic half_tick,
    output logic bit_tick
);

    localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

    // An 8-bit half-period counter plus a phase flag covers CLK_DIV up to 255.
    logic [7:0] cnt_q;
    logic       phase_q;
    logic       half_end;

    assign half_end  = run && (cnt_q == HALF_LAST);
    assign half_tick = half_end && !phase_q;
    assign bit_tick  = half_end && phase_q;

    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (run) begin
            if (cnt_q == HALF_LAST) begin
                cnt_q   <= '0;
                phase_q <= ~phase_q;
            end else begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

endmodule

// File: rtl/dino_score_tx.sv
// Score link transmitter: latches a BCD score and shifts it out MSB-first on sclk/sdata/sframe.
// Optional parity period enabled by defining SCORE_TX_PARITY_EN.
module dino_score_tx
    import dino_score_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned CLK_DIV    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic [BCD_W*NUM_DIGITS-1:0]   score_bcd,
    input  logic                          score_valid,
    output logic                          score_ready,
    output logic                          sclk,
    output logic                          sdata,
    output logic                          sframe,
    output logic                          busy,
    output logic                          bcd_err
);

    localparam int unsigned DATA_W = BCD_W * NUM_DIGITS;
    localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    tx_state_e          state_q;
    logic [DATA_W-1:0]  shreg_q;
    logic [CNT_W-1:0]   bitcnt_q;
    logic               sclk_q, sdata_q, sframe_q, bcd_err_q;
`ifdef SCORE_TX_PARITY_EN
    logic               parity_q;
`endif

    logic accept, nibble_err, half_tick, bit_tick;

    assign score_ready = (state_q == IDLE) && ena && rst_n;
    assign accept      = score_valid && score_ready;
    assign busy        = (state_q != IDLE);
    assign sclk        = sclk_q;
    assign sdata       = sdata_q;
    assign sframe      = sframe_q;
    assign bcd_err     = bcd_err_q;

    always_comb begin
        nibble_err = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (score_bcd[i*BCD_W +: BCD_W] > BCD_W'(BCD_MAX))
                nibble_err = 1'b1;
        end
    end

    dino_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (accept),
        .run       (busy),
        .half_tick (half_tick),
        .bit_tick  (bit_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            sclk_q    <= 1'b0;
            sdata_q   <= 1'b0;
            sframe_q  <= 1'b0;
            bcd_err_q <= 1'b0;
`ifdef SCORE_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q   <= START;
                        shreg_q   <= score_bcd;
                        bcd_err_q <= nibble_err;
                        sframe_q  <= 1'b1;
                        bitcnt_q  <= '0;
`ifdef SCORE_TX_PARITY_EN
                        parity_q  <= ^score_bcd;
`endif
                    end
                end
                START: begin
                    if (bit_tick) begin
                        state_q  <= SHIFT;
                        sdata_q  <= shreg_q[DATA_W-1];
                        shreg_q  <= shreg_q << 1;
                        bitcnt_q <= '0;
                    end
                end
                SHIFT: begin
                    if (half_tick)
                        sclk_q <= 1'b1;
                    if (bit_tick) begin
                        sclk_q <= 1'b0;
                        if (bitcnt_q == LAST_BIT) begin
                            bitcnt_q <= '0;
`ifdef SCORE_TX_PARITY_EN
                            state_q  <= PARITY;
                            sdata_q  <= parity_q;
`else
                            state_q  <= STOP;
                            sdata_q  <= 1'b0;
                            sframe_q <= 1'b0;
`endif
                        end else begin
                            bitcnt_q <= bitcnt_q + CNT_W'(1);
                            sdata_q  <= shreg_q[DATA_W-1];
                            shreg_q  <= shreg_q << 1;
                        end
                    end
                end
`ifdef SCORE_TX_PARITY_EN
                PARITY: begin
                    if (half_tick)
                        sclk_q <= 1'b1;
                    if (bit_tick) begin
                        state_q  <= STOP;
                        sclk_q   <= 1'b0;
                        sdata_q  <= 1'b0;
                        sframe_q <= 1'b0;
                    end
                end
`endif
                STOP: begin
                    if (bit_tick)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dino_score_tx.sv
// Directed bench for dino_score_tx; a negedge monitor recovers sdata at each sclk rise.
module tb_dino_score_tx;

`ifdef SCORE_TX_PARITY_EN
    localparam bit          PAR_EN     = 1'b1;
    localparam int unsigned FRAME_CYC  = 152;
    localparam int unsigned SFRAME_CYC = 144;
    localparam int unsigned NBITS      = 17;
`else
    localparam bit          PAR_EN     = 1'b0;
    localparam int unsigned FRAME_CYC  = 144;
    localparam int unsigned SFRAME_CYC = 136;
    localparam int unsigned NBITS      = 16;
`endif

    logic        clk = 1'b0;
    logic        rst_n, ena, score_valid;
    logic [15:0] score_bcd;
    logic        score_ready, sclk, sdata, sframe, busy, bcd_err;

    always #5 clk = ~clk;

    dino_score_tx #(
        .NUM_DIGITS (4),
        .CLK_DIV    (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .score_bcd   (score_bcd),
        .score_valid (score_valid),
        .score_ready (score_ready),
        .sclk        (sclk),
        .sdata       (sdata),
        .sframe      (sframe),
        .busy        (busy),
        .bcd_err     (bcd_err)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] rx_data    = '0;
    int          rx_bits    = 0;
    int          busy_cnt   = 0;
    int          sframe_cnt = 0;
    logic        prev_sclk  = 1'b0;
    int          b_bits, b_busy, b_sf;

    always @(negedge clk) begin
        if (sclk === 1'b1 && prev_sclk === 1'b0) begin
            rx_data = {rx_data[30:0], sdata};
            rx_bits++;
        end
        prev_sclk = sclk;
        if (busy === 1'b1)   busy_cnt++;
        if (sframe === 1'b1) sframe_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic mark();
        b_bits = rx_bits;
        b_busy = busy_cnt;
        b_sf   = sframe_cnt;
    endtask

    task automatic accept_score(input logic [15:0] d);
        score_bcd   = d;
        score_valid = 1'b1;
        tick();
        score_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    function automatic logic [31:0] fr(input logic [15:0] d, input logic p);
        return PAR_EN ? {15'd0, d, p} : {16'd0, d};
    endfunction

    task automatic check_frame(input string tag, input logic [31:0] exp);
        logic [31:0] mask;
        mask = PAR_EN ? 32'h1_FFFF : 32'h0_FFFF;
        chk({tag, "_bits"}, 32'(rx_bits - b_bits), 32'(NBITS));
        chk({tag, "_data"}, rx_data & mask, exp);
        chk({tag, "_busy"}, 32'(busy_cnt - b_busy), 32'(FRAME_CYC));
        chk({tag, "_sframe"}, 32'(sframe_cnt - b_sf), 32'(SFRAME_CYC));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        ena         = 1'b1;
        score_valid = 1'b0;
        score_bcd   = '0;
        repeat (3) tick();
        chk("rst_ready", 32'(score_ready), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_outs",  {29'd0, sclk, sdata, sframe}, 0);
        chk("rst_err",   32'(bcd_err), 0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 32'(score_ready), 1);

        // Single frame 1234
        mark();
        accept_score(16'h1234);
        chk("f1_busy_on",  32'(busy), 1);
        chk("f1_sframe_on", 32'(sframe), 1);
        chk("f1_ready_off", 32'(score_ready), 0);
        wait_idle("f1");
        check_frame("f1", fr(16'h1234, 1'b1));
        chk("f1_ready_back", 32'(score_ready), 1);
        chk("f1_err", 32'(bcd_err), 0);

        // Back-to-back with valid held; score changes mid-frame
        mark();
        score_bcd   = 16'h0009;
        score_valid = 1'b1;
        tick();
        score_bcd = 16'h9999;
        wait_idle("b1");
        check_frame("b1", fr(16'h0009, 1'b0));
        chk("b1_ready", 32'(score_ready), 1);
        mark();
        tick();
        chk("b2_gap", 32'(busy), 1);
        score_valid = 1'b0;
        score_bcd   = 16'h5555;
        wait_idle("b2");
        check_frame("b2", fr(16'h9999, 1'b0));

        // Invalid nibble is sent as-is and flagged until next accept
        mark();
        accept_score(16'h12A4);
        chk("e1_err_set", 32'(bcd_err), 1);
        wait_idle("e1");
        check_frame("e1", fr(16'h12A4, 1'b1));
        chk("e1_err_hold", 32'(bcd_err), 1);
        mark();
        accept_score(16'h0000);
        chk("e2_err_clr", 32'(bcd_err), 0);
        wait_idle("e2");
        check_frame("e2", fr(16'h0000, 1'b0));

        // Reset at cycle 50 of a frame
        accept_score(16'h1234);
        repeat (48) tick();
        chk("r_sframe_pre", 32'(sframe), 1);
        rst_n = 1'b0;
        tick();
        chk("r_outs", {29'd0, sclk, sdata, sframe}, 0);
        chk("r_busy", 32'(busy), 0);
        chk("r_ready", 32'(score_ready), 0);
        rst_n = 1'b1;
        #1;
        chk("r_ready_back", 32'(score_ready), 1);
        tick();
        chk("r_no_resume", 32'(busy), 0);

        // ena low blocks accepts
        ena         = 1'b0;
        score_bcd   = 16'h1234;
        score_valid = 1'b1;
        #1;
        chk("n_ready", 32'(score_ready), 0);
        repeat (5) tick();
        chk("n_busy", 32'(busy), 0);
        score_valid = 1'b0;
        ena         = 1'b1;

        // ena dropped mid-frame: frame completes
        mark();
        accept_score(16'h1234);
        repeat (19) tick();
        ena = 1'b0;
        wait_idle("d1");
        check_frame("d1", fr(16'h1234, 1'b1));
        chk("d1_ready_off", 32'(score_ready), 0);
        ena = 1'b1;
        #1;
        chk("d1_ready_on", 32'(score_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
